alu_operand_driver: RTL and testbench
=====================================

Name: alu_operand_driver

Overview:
Initiator-side sequencer for the TP1 ALU top's three-phase register-load interface.
- Accepts a complete command (operand A, operand B, opcode) over a valid/ready handshake.
- Replays it onto the shared data bus as enable_1 / enable_2 / enable_3 load pulses.
- Waits a fixed settle time, captures the ALU result/carry/zero, and returns them over a valid/ready response channel.
- Sits between a command source (e.g. the UART command decoder) and the ALU top.

Parameters:
- NB_DATA, 8, operand/result width and data-bus width.
- NB_OP, 6, opcode width; must satisfy NB_OP <= NB_DATA.
- GAP_CYCLES, 1, idle cycles after each load pulse (0 allowed).
- RESULT_WAIT, 2, cycles between the enable_3 pulse and result capture (>= 1).

Ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready (IDLE only).
- i_cmd_a  in  NB_DATA  operand A.
- i_cmd_b  in  NB_DATA  operand B.
- i_cmd_op  in  NB_OP  ALU opcode.
- o_data  out  NB_DATA  data bus to the ALU top.
- o_enable_1  out  1  load-A strobe.
- o_enable_2  out  1  load-B strobe.
- o_enable_3  out  1  load-opcode strobe.
- i_alu_data  in  NB_DATA  ALU result.
- i_alu_carry  in  1  ALU carry.
- i_alu_zero  in  1  ALU zero flag.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accepted.
- o_rsp_data  out  NB_DATA  captured result.
- o_rsp_carry  out  1  captured carry.
- o_rsp_zero  out  1  captured zero.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE.
  - All enables, o_data, o_rsp_*, o_busy and internal counters clear to 0; o_cmd_ready=1.
  - Reset mid-sequence aborts it; no partial response is ever issued.
- FSM states: IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, LOAD_OP, WAIT, RESP.
- IDLE: o_cmd_ready=1. When i_cmd_valid && o_cmd_ready in cycle t:
  - A, B and op are latched into internal registers.
  - Next state is LOAD_A.
  - Input changes after acceptance have no effect.
- LOAD_A (1 cycle): o_enable_1=1, o_data=A.
- GAP_A (GAP_CYCLES cycles): all enables 0, o_data holds A. Skipped when GAP_CYCLES=0.
- LOAD_B / GAP_B: same pattern with o_enable_2 and B.
- LOAD_OP (1 cycle): o_enable_3=1, o_data = {op, (NB_DATA-NB_OP) zero bits}; with defaults, op 6'b100010 gives 8'h88.
  - o_data holds this value through WAIT.
- WAIT (RESULT_WAIT cycles): counter counts down. In the last WAIT cycle, i_alu_data/carry/zero are registered into o_rsp_*.
- RESP: o_rsp_valid=1; o_rsp_* stay stable until i_rsp_ready=1.
  - On handshake: return to IDLE, o_rsp_valid=0 next cycle.
  - o_rsp_data/carry/zero keep their last value until the next capture.
- Latency: accept at t gives o_rsp_valid rising at t + 4 + 2*GAP_CYCLES + RESULT_WAIT (8 with defaults).
- Invariants:
  - At most one enable high in any cycle.
  - A new command is never accepted while o_busy=1.
- The response handshake and a new command can never coincide (ready is low in RESP). Minimum command spacing is therefore latency + 1 cycles.
- All counter widths are $clog2(max+1). Counters never wrap: they saturate by design because they are reloaded on state entry.

Optional Feature:
Macro ALU_DRIVER_SELFCHECK_EN.
- Defined: adds output o_rsp_mismatch (1 bit), registered at capture alongside o_rsp_*.
  - Compares the ALU result against an internal golden model for ADD, SUB, AND, OR, XOR, NOR, SRA, SRL.
  - Carry is compared for ADD/SUB only. SUB carry is bit [NB_DATA] of A + (~B + 1) computed at NB_DATA+1 bits, i.e. carry=1 iff A >= B.
  - Zero is compared for all supported ops.
  - Unknown opcode forces mismatch=0.
- Undefined: the port and all checking logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010;
  - the FSM state enum type;
  - default widths NB_DATA / NB_OP.
- One natural sub-module: alu_ref_model, a combinational golden model, instantiated only under ALU_DRIVER_SELFCHECK_EN.

Test Plan:
1. Command A=50, B=20, op=SUB; stub ALU returns 30/c1/z0, defaults.
   - Required: enable_1 at t+1 with o_data=50; enable_2 at t+3 with o_data=20; enable_3 at t+5 with o_data=8'h88.
   - o_rsp_valid at t+8 with data=30, carry=1, zero=0.
2. A=10, B=20, SUB; ALU returns 246/c0/z0 → response data=246 ($signed -10), carry=0, zero=0.
3. A=25, B=25, SUB; ALU returns 0/c1/z1 → response data=0, carry=1, zero=1.
4. Hold i_rsp_ready=0 for 5 cycles during RESP while pulsing i_cmd_valid with a new command.
   - Required: o_rsp_* stable, o_cmd_ready=0, new command not accepted; accepted the cycle after the response handshake completes.
5. Drop i_reset during GAP_B.
   - Required: all enables and o_busy go to 0 immediately, o_rsp_valid stays 0, o_cmd_ready=1 after release.
   - A following 255-1 SUB command completes normally (data=254, carry=1).
6. Instance with GAP_CYCLES=0, RESULT_WAIT=1: enables on consecutive cycles t+1..t+3, o_rsp_valid at t+5.
   - With ALU_DRIVER_SELFCHECK_EN and stub ALU returning 31 for 50-20 → o_rsp_mismatch=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, driver FSM state type and default widths
package alu_pkg;
    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_GAP_A,
        S_LOAD_B,
        S_GAP_B,
        S_LOAD_OP,
        S_WAIT,
        S_RESP
    } drv_state_t;
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden ALU that flags a disagreeing result/carry/zero
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    input  logic [NB_DATA-1:0] alu_data,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic               mismatch
);
    logic [NB_DATA:0]   sum;
    logic [NB_DATA-1:0] res;
    logic               carry_chk;
    logic               known;
    // expected result per opcode; carry only checked for ADD/SUB, unknown ops never flag
    always_comb begin
        sum       = '0;
        res       = '0;
        carry_chk = 1'b0;
        known     = 1'b1;
        case (op)
            NB_OP'(OP_ADD): begin
                sum       = {1'b0, a} + {1'b0, b};
                res       = sum[NB_DATA-1:0];
                carry_chk = 1'b1;
            end
            NB_OP'(OP_SUB): begin
                sum       = {1'b0, a} + {1'b0, ~b} + {{NB_DATA{1'b0}}, 1'b1};
                res       = sum[NB_DATA-1:0];
                carry_chk = 1'b1;
            end
            NB_OP'(OP_AND): res = a & b;
            NB_OP'(OP_OR):  res = a | b;
            NB_OP'(OP_XOR): res = a ^ b;
            NB_OP'(OP_NOR): res = ~(a | b);
            NB_OP'(OP_SRA): res = $signed(a) >>> b;
            NB_OP'(OP_SRL): res = a >> b;
            default:        known = 1'b0;
        endcase
        mismatch = known & ((alu_data != res) | (alu_zero != (res == '0)) |
                            (carry_chk & (alu_carry != sum[NB_DATA])));
    end
endmodule

// File: rtl/alu_operand_driver.sv
// alu_operand_driver: replays a command as A/B/opcode load pulses, waits, returns the ALU result.
// Optional ALU_DRIVER_SELFCHECK_EN adds o_rsp_mismatch from an internal golden model.
module alu_operand_driver
    import alu_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_OP       = NB_OP_DEF,
    parameter int GAP_CYCLES  = 1,
    parameter int RESULT_WAIT = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [NB_DATA-1:0] i_cmd_a,
    input  logic [NB_DATA-1:0] i_cmd_b,
    input  logic [NB_OP-1:0]   i_cmd_op,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_enable_1,
    output logic               o_enable_2,
    output logic               o_enable_3,
    input  logic [NB_DATA-1:0] i_alu_data,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_DATA-1:0] o_rsp_data,
    output logic               o_rsp_carry,
    output logic               o_rsp_zero,
`ifdef ALU_DRIVER_SELFCHECK_EN
    output logic               o_rsp_mismatch,
`endif
    output logic               o_busy
);
    localparam int CNT_MAX = (GAP_CYCLES > RESULT_WAIT) ? GAP_CYCLES : RESULT_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] WAIT_LD = CW'(RESULT_WAIT - 1);
    drv_state_t         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] op_word;
    logic               accept;
    logic               capture;
    assign accept  = (state == S_IDLE) && i_cmd_valid;
    assign capture = (state == S_WAIT) && (cnt == '0);
    assign op_word = NB_DATA'(op_q) << (NB_DATA - NB_OP);
    assign o_cmd_ready = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign o_enable_1  = (state == S_LOAD_A);
    assign o_enable_2  = (state == S_LOAD_B);
    assign o_enable_3  = (state == S_LOAD_OP);
    assign o_rsp_valid = (state == S_RESP);
    assign o_data = (state == S_LOAD_A  || state == S_GAP_A) ? a_q :
                    (state == S_LOAD_B  || state == S_GAP_B) ? b_q :
                    (state == S_LOAD_OP || state == S_WAIT)  ? op_word : '0;
    // next state; counters are reloaded on entry and hold at zero instead of wrapping
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE:    state_n = i_cmd_valid ? S_LOAD_A : S_IDLE;
            S_LOAD_A: begin
                state_n = (GAP_CYCLES == 0) ? S_LOAD_B : S_GAP_A;
                cnt_n   = GAP_LD;
            end
            S_GAP_A: begin
                state_n = (cnt == '0) ? S_LOAD_B : S_GAP_A;
                cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
            end
            S_LOAD_B: begin
                state_n = (GAP_CYCLES == 0) ? S_LOAD_OP : S_GAP_B;
                cnt_n   = GAP_LD;
            end
            S_GAP_B: begin
                state_n = (cnt == '0) ? S_LOAD_OP : S_GAP_B;
                cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
            end
            S_LOAD_OP: begin
                state_n = S_WAIT;
                cnt_n   = WAIT_LD;
            end
            S_WAIT: begin
                state_n = (cnt == '0) ? S_RESP : S_WAIT;
                cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
            end
            S_RESP:    state_n = i_rsp_ready ? S_IDLE : S_RESP;
            default:   state_n = S_IDLE;
        endcase
    end
    // state and counter registers; reset aborts any sequence in flight
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // command latch on acceptance and result capture in the last settle cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            o_rsp_data  <= '0;
            o_rsp_carry <= 1'b0;
            o_rsp_zero  <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= i_cmd_a;
                b_q  <= i_cmd_b;
                op_q <= i_cmd_op;
            end
            if (capture) begin
                o_rsp_data  <= i_alu_data;
                o_rsp_carry <= i_alu_carry;
                o_rsp_zero  <= i_alu_zero;
            end
        end
    end
`ifdef ALU_DRIVER_SELFCHECK_EN
    logic mismatch;
    alu_ref_model #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_ref (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .alu_data (i_alu_data),
        .alu_carry(i_alu_carry),
        .alu_zero (i_alu_zero),
        .mismatch (mismatch)
    );
    // mismatch flag captured together with the response fields
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            o_rsp_mismatch <= 1'b0;
        else if (capture)
            o_rsp_mismatch <= mismatch;
    end
`endif
endmodule

// File: tb/tb_alu_operand_driver.sv
// tb_alu_operand_driver: randomized self-checking bench with stub ALUs on a default and a zero-gap instance
module tb_alu_operand_driver;
    import alu_pkg::*;
    localparam int G = 1;
    localparam int W = 2;
    localparam int L = 4 + 2 * G + W;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    logic       cmd_valid = 1'b0, rsp_ready = 1'b0, cmd_ready, rsp_valid, busy;
    logic [7:0] cmd_a = '0, cmd_b = '0, bus, alu_d, rsp_d;
    logic [5:0] cmd_op = '0;
    logic       en1, en2, en3, alu_c, alu_z, rsp_c, rsp_z;
    logic       cmd_valid_f = 1'b0, rsp_ready_f = 1'b0, cmd_ready_f, rsp_valid_f, busy_f;
    logic [7:0] cmd_a_f = '0, cmd_b_f = '0, bus_f, alu_d_f, alu_raw_f, rsp_d_f;
    logic [5:0] cmd_op_f = '0;
    logic       en1_f, en2_f, en3_f, alu_c_f, alu_z_f, rsp_c_f, rsp_z_f;
    logic       force_bad = 1'b0;
`ifdef ALU_DRIVER_SELFCHECK_EN
    logic       mis, mis_f;
`endif
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [7:0] d;
        logic       c;
        c = 1'b0;
        case (op)
            OP_ADD:  {c, d} = {1'b0, a} + {1'b0, b};
            OP_SUB:  begin d = a - b; c = (a >= b); end
            OP_AND:  d = a & b;
            OP_OR:   d = a | b;
            OP_XOR:  d = a ^ b;
            OP_NOR:  d = ~(a | b);
            OP_SRA:  d = $signed(a) >>> b;
            OP_SRL:  d = a >> b;
            default: d = 8'd0;
        endcase
        return {c, d == 8'd0, d};
    endfunction
    logic [7:0] ra, rb, ra_f, rb_f;
    logic [5:0] rop, rop_f;
    always @(posedge clk) begin
        if (en1) ra <= bus;
        if (en2) rb <= bus;
        if (en3) rop <= bus[7:2];
        if (en1_f) ra_f <= bus_f;
        if (en2_f) rb_f <= bus_f;
        if (en3_f) rop_f <= bus_f[7:2];
    end
    assign {alu_c, alu_z, alu_d} = alu_fn(ra, rb, rop);
    assign {alu_c_f, alu_z_f, alu_raw_f} = alu_fn(ra_f, rb_f, rop_f);
    assign alu_d_f = force_bad ? 8'd31 : alu_raw_f;
    alu_operand_driver dut (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_op(cmd_op), .o_data(bus),
        .o_enable_1(en1), .o_enable_2(en2), .o_enable_3(en3),
        .i_alu_data(alu_d), .i_alu_carry(alu_c), .i_alu_zero(alu_z),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_d),
        .o_rsp_carry(rsp_c), .o_rsp_zero(rsp_z),
`ifdef ALU_DRIVER_SELFCHECK_EN
        .o_rsp_mismatch(mis),
`endif
        .o_busy(busy)
    );
    alu_operand_driver #(.GAP_CYCLES(0), .RESULT_WAIT(1)) dut_f (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid_f), .o_cmd_ready(cmd_ready_f),
        .i_cmd_a(cmd_a_f), .i_cmd_b(cmd_b_f), .i_cmd_op(cmd_op_f), .o_data(bus_f),
        .o_enable_1(en1_f), .o_enable_2(en2_f), .o_enable_3(en3_f),
        .i_alu_data(alu_d_f), .i_alu_carry(alu_c_f), .i_alu_zero(alu_z_f),
        .o_rsp_valid(rsp_valid_f), .i_rsp_ready(rsp_ready_f), .o_rsp_data(rsp_d_f),
        .o_rsp_carry(rsp_c_f), .o_rsp_zero(rsp_z_f),
`ifdef ALU_DRIVER_SELFCHECK_EN
        .o_rsp_mismatch(mis_f),
`endif
        .o_busy(busy_f)
    );
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({cmd_ready, busy, en3, en2, en1, rsp_valid, bus} !== {6'b100000, 8'd0}) begin
            fails++; $display("FAIL reset_ctrl got %b/%h want 100000/00", {cmd_ready, busy, en3, en2, en1, rsp_valid}, bus);
        end
        tests++;
        if ({rsp_c, rsp_z, rsp_d, cmd_ready_f, busy_f} !== 12'b0000000000_10) begin
            fails++; $display("FAIL reset_rsp got %b want 000000000010", {rsp_c, rsp_z, rsp_d, cmd_ready_f, busy_f});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_command(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input int hold);
        logic [9:0] exp;
        logic [7:0] dexp;
        logic [2:0] eexp;
        exp = alu_fn(a, b, op);
        @(posedge clk); #1;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_idle got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        for (int k = 1; k <= L; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 6'($urandom);
            eexp = (k == 1) ? 3'b001 : (k == 2 + G) ? 3'b010 : (k == 3 + 2 * G) ? 3'b100 : 3'b000;
            dexp = (k <= 1 + G) ? a : (k <= 2 + 2 * G) ? b : {op, 2'b00};
            tests++;
            if ({en3, en2, en1, rsp_valid, busy} !== {eexp, k == L, 1'b1}) begin
                fails++; $display("FAIL seq_k%0d got %b want %b", k, {en3, en2, en1, rsp_valid, busy}, {eexp, k == L, 1'b1});
            end
            if (k < L) begin
                tests++;
                if (bus !== dexp) begin fails++; $display("FAIL bus_k%0d got %h want %h", k, bus, dexp); end
            end
        end
        tests++;
        if ({rsp_c, rsp_z, rsp_d} !== exp) begin fails++; $display("FAIL rsp got %h want %h", {rsp_c, rsp_z, rsp_d}, exp); end
`ifdef ALU_DRIVER_SELFCHECK_EN
        tests++;
        if (mis !== 1'b0) begin fails++; $display("FAIL mismatch_flag got %b want 0", mis); end
`endif
        for (int h = 0; h < hold; h++) begin
            cmd_valid = h[0]; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = OP_ADD;
            @(posedge clk); #1;
            tests++;
            if ({rsp_valid, cmd_ready, busy, en1, rsp_c, rsp_z, rsp_d} !== {4'b1010, exp}) begin
                fails++; $display("FAIL hold_%0d got %h want %h", h, {rsp_valid, cmd_ready, busy, en1, rsp_c, rsp_z, rsp_d}, {4'b1010, exp});
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, cmd_ready, rsp_c, rsp_z, rsp_d} !== {2'b01, exp}) begin
            fails++; $display("FAIL handshake got %h want %h", {rsp_valid, cmd_ready, rsp_c, rsp_z, rsp_d}, {2'b01, exp});
        end
    endtask
    task automatic test_directed();
        test_command(8'd50, 8'd20, OP_SUB, 0);
        test_command(8'd10, 8'd20, OP_SUB, 0);
        test_command(8'd25, 8'd25, OP_SUB, 0);
    endtask
    task automatic test_backpressure();
        int n;
        test_command(8'd40, 8'd2, OP_ADD, 5);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = 8'd60; cmd_b = 8'd5; cmd_op = OP_XOR;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 8'd7; cmd_b = 8'd9; cmd_op = OP_OR;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_d !== 8'd57) begin fails++; $display("FAIL bp_first got %b/%h want 1/39", rsp_valid, rsp_d); end
        cmd_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            tests++;
            if ({cmd_ready, rsp_valid, en1, rsp_d} !== {3'b010, 8'd57}) begin
                fails++; $display("FAIL bp_hold got %h want %h", {cmd_ready, rsp_valid, en1, rsp_d}, {3'b010, 8'd57});
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++;
        if ({cmd_ready, rsp_valid, en1} !== 3'b100) begin fails++; $display("FAIL bp_idle got %b want 100", {cmd_ready, rsp_valid, en1}); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests++;
        if ({en1, bus} !== {1'b1, 8'd7}) begin fails++; $display("FAIL bp_accept got %h want 107", {en1, bus}); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if ({rsp_valid, rsp_c, rsp_z, rsp_d} !== {3'b100, 8'd15}) begin
            fails++; $display("FAIL bp_second got %h want %h", {rsp_valid, rsp_c, rsp_z, rsp_d}, {3'b100, 8'd15});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask
    task automatic test_reset_mid();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = OP_SUB;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        tests++;
        if ({busy, bus} !== {1'b1, 8'd100}) begin fails++; $display("FAIL gap_b got %h want 164", {busy, bus}); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({en3, en2, en1, busy, rsp_valid, cmd_ready} !== 6'b000001) begin
            fails++; $display("FAIL async_reset got %b want 000001", {en3, en2, en1, busy, rsp_valid, cmd_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 6) begin
            @(posedge clk); #1;
            tests++;
            if ({rsp_valid, cmd_ready, busy, rsp_d} !== {3'b010, 8'd0}) begin
                fails++; $display("FAIL post_reset got %h want %h", {rsp_valid, cmd_ready, busy, rsp_d}, {3'b010, 8'd0});
            end
        end
        test_command(8'd255, 8'd1, OP_SUB, 0);
    endtask
    task automatic test_random();
        logic [5:0] ops [9];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL, 6'b111111};
        for (int i = 0; i < 25; i++)
            test_command(8'($urandom), 8'($urandom_range(0, 9)), ops[$urandom_range(0, 8)], int'($urandom_range(0, 3)));
    endtask
    task automatic test_fast(input logic bad, input logic [7:0] want);
        logic [2:0] eexp;
        logic [7:0] dexp;
        force_bad = bad;
        @(posedge clk); #1;
        cmd_valid_f = 1'b1; cmd_a_f = 8'd50; cmd_b_f = 8'd20; cmd_op_f = OP_SUB;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            cmd_valid_f = 1'b0;
            eexp = (k == 1) ? 3'b001 : (k == 2) ? 3'b010 : (k == 3) ? 3'b100 : 3'b000;
            dexp = (k == 1) ? 8'd50 : (k == 2) ? 8'd20 : 8'h88;
            tests++;
            if ({en3_f, en2_f, en1_f, rsp_valid_f} !== {eexp, k == 5}) begin
                fails++; $display("FAIL fast_k%0d got %b want %b", k, {en3_f, en2_f, en1_f, rsp_valid_f}, {eexp, k == 5});
            end
            if (k < 5) begin
                tests++;
                if (bus_f !== dexp) begin fails++; $display("FAIL fast_bus_k%0d got %h want %h", k, bus_f, dexp); end
            end
        end
        tests++;
        if ({rsp_c_f, rsp_z_f, rsp_d_f} !== {2'b10, want}) begin
            fails++; $display("FAIL fast_rsp got %h want %h", {rsp_c_f, rsp_z_f, rsp_d_f}, {2'b10, want});
        end
`ifdef ALU_DRIVER_SELFCHECK_EN
        tests++;
        if (mis_f !== bad) begin fails++; $display("FAIL fast_mismatch got %b want %b", mis_f, bad); end
`endif
        rsp_ready_f = 1'b1;
        @(posedge clk); #1;
        rsp_ready_f = 1'b0;
        force_bad = 1'b0;
        tests++;
        if ({rsp_valid_f, cmd_ready_f} !== 2'b01) begin fails++; $display("FAIL fast_handshake got %b want 01", {rsp_valid_f, cmd_ready_f}); end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_fast(1'b0, 8'd30);
        test_fast(1'b1, 8'd31);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1);
    end
endmodule
